pipe_ctrl_hazard_unit: RTL and testbench
========================================

// Module: pipe_ctrl_hazard_unit
// PURPOSE
//  Consumer side of the main-decoder control word in the five-stage MIPS pipeline.
//  Carries the ID-stage control bits through ID/EX, EX/MEM and MEM/WB control registers.
//  Detects load-use hazards and inserts one bubble; squashes on taken beq resolved in EX.
//  Drives EX operand forwarding selects and counts stall and flush events.
// PARAMETERS
//  RA_W   5   register-address width
//  CNT_W  16  width of stall_cnt / flush_cnt performance counters
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      asynchronous, active-low reset
//  id_RegDst     in   1      decoded control, ID stage (same meaning as decoder outputs)
//  id_ALUSrc     in   1      "
//  id_MemToReg   in   1      "
//  id_RegWrite   in   1      "
//  id_MemRead    in   1      "
//  id_MemWrite   in   1      "
//  id_Branch     in   1      "
//  id_ALUOp      in   2      "
//  id_rs,id_rt   in   RA_W   source register fields of instruction in ID
//  id_rd         in   RA_W   rd field of instruction in ID
//  ex_zero       in   1      ALU zero flag of instruction currently in EX
//  ex_RegDst,ex_ALUSrc,ex_ALUOp[1:0]  out  registered EX-stage control
//  ex_rs,ex_rt   out  RA_W   registered source fields in EX
//  mem_MemRead,mem_MemWrite          out  registered MEM-stage control
//  wb_MemToReg,wb_RegWrite           out  registered WB-stage control
//  wb_wreg       out  RA_W   destination register for write-back
//  fwd_a,fwd_b   out  2      00 = regfile, 10 = EX/MEM result, 01 = MEM/WB result
//  pc_write      out  1      0 freezes PC
//  ifid_write    out  1      0 holds IF/ID register
//  ifid_flush    out  1      1 clears IF/ID to nop at next edge
//  pc_src        out  1      1 selects branch target (taken beq in EX)
//  stall_cnt     out  CNT_W  number of load-use bubbles inserted
//  flush_cnt     out  CNT_W  number of taken-branch squashes
// BEHAVIOUR
//  - Reset (rst_n=0, async): all control registers, ex_rs/ex_rt/ex_rd, mem_wreg and wb_wreg go to 0.
//    Both counters go to 0. Reset mid-operation discards every in-flight control bit immediately.
//  - Latency: ID control appears on ex_* 1 cycle later, on mem_* after 2 cycles, on wb_* after 3.
//  - ex_wreg = ex_RegDst ? ex_rd : ex_rt. This value is registered into mem_wreg, then wb_wreg.
//  - Load-use: stall = ex_MemRead & (ex_rt!=0) & (ex_rt==id_rs | ex_rt==id_rt).
//  - taken = ex_Branch & ex_zero. pc_src = taken, combinational.
//  - Priority: taken overrides stall. When both are true, only the flush action is applied.
//  - taken: ifid_flush=1; next ID/EX control = all-zero bubble; pc_write=1; ifid_write=1.
//    The squashed instruction pair is the one in IF and the one in ID.
//  - stall (no taken): pc_write=0; ifid_write=0; next ID/EX control = all-zero bubble.
//    ex_rs/ex_rt/ex_rd are still loaded from ID.
//  - Otherwise: pc_write=1, ifid_write=1, ifid_flush=0, and ID/EX loads the id_* values.
//  - EX/MEM and MEM/WB always advance; they are never stalled.
//  - A bubble has RegWrite=MemWrite=MemRead=Branch=0, so it cannot alter architectural state.
//  - fwd_a: 10 if mem_RegWrite & mem_wreg!=0 & mem_wreg==ex_rs.
//    Else 01 if wb_RegWrite & wb_wreg!=0 & wb_wreg==ex_rs. Else 00.
//    The EX/MEM match wins when both match. fwd_b uses the same rule with ex_rt.
//  - Forward selects and stall/taken terms are combinational from registered state plus id_* fields.
//    They must settle within the cycle.
//  - Counters: stall_cnt += 1 on each edge with stall & ~taken; flush_cnt += 1 on each edge with taken.
//    Both saturate at all-ones and do not wrap.
//  - Register $0 never produces a hazard or a forward.
// TESTING
//  - Reset: assert rst_n=0 mid-stream -> all outputs 0 at once (pc_write=1, ifid_write=1 after).
//    Counters read 0.
//  - Pipe latency: R-type control (RegDst=1, RegWrite=1, ALUOp=10) at ID on cycle 0
//    -> ex_* on cycle 1, wb_RegWrite=1 on cycle 3, wb_wreg=id_rd.
//  - Load-use: lw $t0 in EX, id_rs=8 -> pc_write=0, ifid_write=0, next ex_* = 0, stall_cnt=1.
//    The dependent add then proceeds with fwd_a=01.
//  - Branch: beq in EX with ex_zero=1 -> pc_src=1, ifid_flush=1, next ID/EX bubble, flush_cnt=1.
//    With ex_zero=0 -> no flush.
//  - Forward priority: add $3 in MEM and sub $3 in WB, ex_rs=3 -> fwd_a=10.
//    Same case with dest $0 -> fwd_a=00.
//  - Simultaneous events: taken beq in EX while load-use condition is true -> flush only.
//    Expect pc_write=1, stall_cnt unchanged. Counter saturation with CNT_W=2 -> holds at 3.

Source files
------------

// File: rtl/pipe_ctrl_hazard_unit_if.sv
// Bundle between the MIPS ID-stage decoder and the pipeline control/hazard unit:
// decoded ID fields in; staged control, forwarding selects and pipeline steering out.
interface pipe_ctrl_hazard_unit_if #(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 16
);
  logic            id_RegDst;
  logic            id_ALUSrc;
  logic            id_MemToReg;
  logic            id_RegWrite;
  logic            id_MemRead;
  logic            id_MemWrite;
  logic            id_Branch;
  logic [1:0]      id_ALUOp;
  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic [RA_W-1:0] id_rd;
  logic            ex_zero;

  logic            ex_RegDst;
  logic            ex_ALUSrc;
  logic [1:0]      ex_ALUOp;
  logic [RA_W-1:0] ex_rs;
  logic [RA_W-1:0] ex_rt;
  logic            mem_MemRead;
  logic            mem_MemWrite;
  logic            wb_MemToReg;
  logic            wb_RegWrite;
  logic [RA_W-1:0] wb_wreg;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic            pc_write;
  logic            ifid_write;
  logic            ifid_flush;
  logic            pc_src;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_RegDst, id_ALUSrc, id_MemToReg, id_RegWrite, id_MemRead, id_MemWrite,
           id_Branch, id_ALUOp, id_rs, id_rt, id_rd, ex_zero,
    input  ex_RegDst, ex_ALUSrc, ex_ALUOp, ex_rs, ex_rt, mem_MemRead, mem_MemWrite,
           wb_MemToReg, wb_RegWrite, wb_wreg, fwd_a, fwd_b, pc_write, ifid_write,
           ifid_flush, pc_src, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_RegDst, id_ALUSrc, id_MemToReg, id_RegWrite, id_MemRead, id_MemWrite,
           id_Branch, id_ALUOp, id_rs, id_rt, id_rd, ex_zero,
    output ex_RegDst, ex_ALUSrc, ex_ALUOp, ex_rs, ex_rt, mem_MemRead, mem_MemWrite,
           wb_MemToReg, wb_RegWrite, wb_wreg, fwd_a, fwd_b, pc_write, ifid_write,
           ifid_flush, pc_src, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl_hazard_unit.sv
// Five-stage MIPS control pipeline: ID/EX, EX/MEM, MEM/WB control registers,
// load-use stall, taken-beq squash, EX operand forwarding and event counters.
module pipe_ctrl_hazard_unit #(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  pipe_ctrl_hazard_unit_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic            ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write;
  logic            ex_mem_read, ex_mem_write, ex_branch;
  logic [1:0]      ex_alu_op;
  logic [RA_W-1:0] ex_rs, ex_rt, ex_rd;
  logic            mem_mem_to_reg, mem_reg_write, mem_mem_read, mem_mem_write;
  logic [RA_W-1:0] mem_wreg;
  logic            wb_mem_to_reg, wb_reg_write;
  logic [RA_W-1:0] wb_wreg;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  logic            stall, taken, bubble;
  logic [RA_W-1:0] ex_wreg;
  logic [1:0]      fwd_a, fwd_b;

  // EX/MEM result wins over MEM/WB; $0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src);
    if (mem_reg_write && (mem_wreg != '0) && (mem_wreg == src)) return 2'b10;
    if (wb_reg_write  && (wb_wreg  != '0) && (wb_wreg  == src)) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    ex_wreg = ex_reg_dst ? ex_rd : ex_rt;
    stall   = ex_mem_read && (ex_rt != '0) &&
              ((ex_rt == bus.id_rs) || (ex_rt == bus.id_rt));
    taken   = ex_branch && bus.ex_zero;
    bubble  = stall || taken;
    fwd_a   = fwd_sel(ex_rs);
    fwd_b   = fwd_sel(ex_rt);
  end

  // ID/EX: control zeroed on a bubble, register fields always follow ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_reg_dst    <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_op     <= 2'b00;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
    end else begin
      ex_reg_dst    <= bubble ? 1'b0  : bus.id_RegDst;
      ex_alu_src    <= bubble ? 1'b0  : bus.id_ALUSrc;
      ex_mem_to_reg <= bubble ? 1'b0  : bus.id_MemToReg;
      ex_reg_write  <= bubble ? 1'b0  : bus.id_RegWrite;
      ex_mem_read   <= bubble ? 1'b0  : bus.id_MemRead;
      ex_mem_write  <= bubble ? 1'b0  : bus.id_MemWrite;
      ex_branch     <= bubble ? 1'b0  : bus.id_Branch;
      ex_alu_op     <= bubble ? 2'b00 : bus.id_ALUOp;
      ex_rs         <= bus.id_rs;
      ex_rt         <= bus.id_rt;
      ex_rd         <= bus.id_rd;
    end
  end

  // EX/MEM and MEM/WB advance every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_mem_to_reg <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_wreg       <= '0;
      wb_mem_to_reg  <= 1'b0;
      wb_reg_write   <= 1'b0;
      wb_wreg        <= '0;
    end else begin
      mem_mem_to_reg <= ex_mem_to_reg;
      mem_reg_write  <= ex_reg_write;
      mem_mem_read   <= ex_mem_read;
      mem_mem_write  <= ex_mem_write;
      mem_wreg       <= ex_wreg;
      wb_mem_to_reg  <= mem_mem_to_reg;
      wb_reg_write   <= mem_reg_write;
      wb_wreg        <= mem_wreg;
    end
  end

  // Saturating event counters; a taken branch masks a coincident stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !taken && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (taken && (flush_cnt != CNT_MAX))           flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.ex_RegDst    = ex_reg_dst;
  assign bus.ex_ALUSrc    = ex_alu_src;
  assign bus.ex_ALUOp     = ex_alu_op;
  assign bus.ex_rs        = ex_rs;
  assign bus.ex_rt        = ex_rt;
  assign bus.mem_MemRead  = mem_mem_read;
  assign bus.mem_MemWrite = mem_mem_write;
  assign bus.wb_MemToReg  = wb_mem_to_reg;
  assign bus.wb_RegWrite  = wb_reg_write;
  assign bus.wb_wreg      = wb_wreg;
  assign bus.fwd_a        = fwd_a;
  assign bus.fwd_b        = fwd_b;
  assign bus.pc_write     = !(stall && !taken);
  assign bus.ifid_write   = !(stall && !taken);
  assign bus.ifid_flush   = taken;
  assign bus.pc_src       = taken;
  assign bus.stall_cnt    = stall_cnt;
  assign bus.flush_cnt    = flush_cnt;
endmodule

// File: tb/tb_pipe_ctrl_hazard_unit.sv
// Bench for pipe_ctrl_hazard_unit: directed scenarios then random traffic, each cycle
// compared with a stage-record pipeline model; a CNT_W=2 copy checks counter saturation.
module tb_pipe_ctrl_hazard_unit;
  localparam int unsigned RA_W  = 5;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SAT_W = 2;

  typedef struct packed {
    logic RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch;
    logic [1:0] ALUOp;
    logic [4:0] rs, rt, rd;
    logic       zero;
  } in_t;
  localparam int IN_W = $bits(in_t);

  // One instruction's record as it moves EX -> MEM -> WB.
  typedef struct packed {
    logic RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch;
    logic [1:0] ALUOp;
    logic [4:0] rs, rt, wreg;
  } stg_t;

  logic clk, rst_n;
  pipe_ctrl_hazard_unit_if #(.RA_W(RA_W), .CNT_W(CNT_W)) bus ();
  pipe_ctrl_hazard_unit_if #(.RA_W(RA_W), .CNT_W(SAT_W)) sbus ();

  pipe_ctrl_hazard_unit #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  pipe_ctrl_hazard_unit #(.RA_W(RA_W), .CNT_W(SAT_W)) dut_sat (.clk(clk), .rst_n(rst_n), .bus(sbus));

  assign sbus.id_RegDst   = bus.id_RegDst;
  assign sbus.id_ALUSrc   = bus.id_ALUSrc;
  assign sbus.id_MemToReg = bus.id_MemToReg;
  assign sbus.id_RegWrite = bus.id_RegWrite;
  assign sbus.id_MemRead  = bus.id_MemRead;
  assign sbus.id_MemWrite = bus.id_MemWrite;
  assign sbus.id_Branch   = bus.id_Branch;
  assign sbus.id_ALUOp    = bus.id_ALUOp;
  assign sbus.id_rs       = bus.id_rs;
  assign sbus.id_rt       = bus.id_rt;
  assign sbus.id_rd       = bus.id_rd;
  assign sbus.ex_zero     = bus.ex_zero;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  in_t  cur;
  stg_t pipe [3];
  int   m_stall, m_flush;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic in_t rtype(input int rs, input int rt, input int rd);
    in_t r = '0;
    r.RegDst = 1'b1; r.RegWrite = 1'b1; r.ALUOp = 2'b10;
    r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd);
    return r;
  endfunction

  function automatic in_t lw(input int rs, input int rt);
    in_t r = '0;
    r.ALUSrc = 1'b1; r.MemToReg = 1'b1; r.RegWrite = 1'b1; r.MemRead = 1'b1;
    r.rs = 5'(rs); r.rt = 5'(rt);
    return r;
  endfunction

  function automatic in_t beq(input int rs, input int rt);
    in_t r = '0;
    r.Branch = 1'b1; r.ALUOp = 2'b01;
    r.rs = 5'(rs); r.rt = 5'(rt);
    return r;
  endfunction

  function automatic bit m_is_stall();
    return pipe[0].MemRead && pipe[0].rt != 0 && (pipe[0].rt == cur.rs || pipe[0].rt == cur.rt);
  endfunction

  function automatic bit m_is_taken();
    return pipe[0].Branch && cur.zero;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] r);
    if (r != 0 && pipe[1].RegWrite && pipe[1].wreg == r) return 2'b10;
    if (r != 0 && pipe[2].RegWrite && pipe[2].wreg == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat(input int cnt, input int w);
    int mx = (1 << w) - 1;
    return (cnt > mx) ? mx : cnt;
  endfunction

  task automatic apply();
    bus.id_RegDst = cur.RegDst;   bus.id_ALUSrc = cur.ALUSrc;     bus.id_MemToReg = cur.MemToReg;
    bus.id_RegWrite = cur.RegWrite; bus.id_MemRead = cur.MemRead; bus.id_MemWrite = cur.MemWrite;
    bus.id_Branch = cur.Branch;   bus.id_ALUOp = cur.ALUOp;
    bus.id_rs = cur.rs; bus.id_rt = cur.rt; bus.id_rd = cur.rd; bus.ex_zero = cur.zero;
  endtask

  task automatic check_all();
    bit st = m_is_stall();
    bit tk = m_is_taken();
    check("ex_RegDst",    32'(bus.ex_RegDst),    32'(pipe[0].RegDst));
    check("ex_ALUSrc",    32'(bus.ex_ALUSrc),    32'(pipe[0].ALUSrc));
    check("ex_ALUOp",     32'(bus.ex_ALUOp),     32'(pipe[0].ALUOp));
    check("ex_rs",        32'(bus.ex_rs),        32'(pipe[0].rs));
    check("ex_rt",        32'(bus.ex_rt),        32'(pipe[0].rt));
    check("mem_MemRead",  32'(bus.mem_MemRead),  32'(pipe[1].MemRead));
    check("mem_MemWrite", 32'(bus.mem_MemWrite), 32'(pipe[1].MemWrite));
    check("wb_MemToReg",  32'(bus.wb_MemToReg),  32'(pipe[2].MemToReg));
    check("wb_RegWrite",  32'(bus.wb_RegWrite),  32'(pipe[2].RegWrite));
    check("wb_wreg",      32'(bus.wb_wreg),      32'(pipe[2].wreg));
    check("fwd_a",        32'(bus.fwd_a),        32'(m_fwd(pipe[0].rs)));
    check("fwd_b",        32'(bus.fwd_b),        32'(m_fwd(pipe[0].rt)));
    check("pc_write",     32'(bus.pc_write),     32'(!(st && !tk)));
    check("ifid_write",   32'(bus.ifid_write),   32'(!(st && !tk)));
    check("ifid_flush",   32'(bus.ifid_flush),   32'(tk));
    check("pc_src",       32'(bus.pc_src),       32'(tk));
    check("stall_cnt",    32'(bus.stall_cnt),    32'(sat(m_stall, CNT_W)));
    check("flush_cnt",    32'(bus.flush_cnt),    32'(sat(m_flush, CNT_W)));
    check("sat_stall",    32'(sbus.stall_cnt),   32'(sat(m_stall, SAT_W)));
    check("sat_flush",    32'(sbus.flush_cnt),   32'(sat(m_flush, SAT_W)));
  endtask

  task automatic advance();
    bit   st = m_is_stall();
    bit   tk = m_is_taken();
    stg_t n  = '0;
    if (!(st || tk)) begin
      n.RegDst = cur.RegDst; n.ALUSrc = cur.ALUSrc; n.MemToReg = cur.MemToReg;
      n.RegWrite = cur.RegWrite; n.MemRead = cur.MemRead; n.MemWrite = cur.MemWrite;
      n.Branch = cur.Branch; n.ALUOp = cur.ALUOp;
    end
    n.rs   = cur.rs;
    n.rt   = cur.rt;
    n.wreg = n.RegDst ? cur.rd : cur.rt;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = n;
    if (tk) m_flush++;
    else if (st) m_stall++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // Drive current inputs, compare everything, then cross one clock edge.
  task automatic step();
    apply();
    #3;
    check_all();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic probe();
    apply();
    #2;
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check("rst_pc_write", 32'(bus.pc_write), 32'd1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    cur   = '0;
    model_reset();
    apply();
    #12;
    check_all();
    rst_n = 1'b1;
    @(posedge clk);
    advance();
    #1;

    // Pipe latency of an R-type
    cur = rtype(1, 2, 5);
    step();
    check("lat_ex_RegDst", 32'(bus.ex_RegDst), 32'd1);
    check("lat_ex_ALUOp",  32'(bus.ex_ALUOp),  32'd2);
    cur = '0;
    step();
    step();
    check("lat_wb_RegWrite", 32'(bus.wb_RegWrite), 32'd1);
    check("lat_wb_wreg",     32'(bus.wb_wreg),     32'd5);

    // Load-use on $t0 then forwarded from MEM/WB
    cur = lw(9, 8);
    step();
    cur = rtype(8, 10, 11);
    probe();
    check("lu_pc_write",   32'(bus.pc_write),   32'd0);
    check("lu_ifid_write", 32'(bus.ifid_write), 32'd0);
    step();
    check("lu_bubble_regdst", 32'(bus.ex_RegDst), 32'd0);
    check("lu_bubble_aluop",  32'(bus.ex_ALUOp),  32'd0);
    check("lu_stall_cnt",     32'(bus.stall_cnt), 32'd1);
    step();
    check("lu_fwd_a", 32'(bus.fwd_a), 32'd1);

    // Taken and not-taken beq
    cur = beq(1, 2);
    step();
    cur = rtype(3, 4, 5);
    cur.zero = 1'b1;
    probe();
    check("br_pc_src",     32'(bus.pc_src),     32'd1);
    check("br_ifid_flush", 32'(bus.ifid_flush), 32'd1);
    check("br_pc_write",   32'(bus.pc_write),   32'd1);
    step();
    check("br_bubble_aluop", 32'(bus.ex_ALUOp),  32'd0);
    check("br_flush_cnt",    32'(bus.flush_cnt), 32'd1);
    cur = beq(1, 2);
    step();
    cur = rtype(3, 4, 5);
    probe();
    check("nt_pc_src",     32'(bus.pc_src),     32'd0);
    check("nt_ifid_flush", 32'(bus.ifid_flush), 32'd0);
    step();

    // Forward priority, then the same shape with $0
    cur = rtype(1, 2, 3); step();
    cur = rtype(4, 5, 3); step();
    cur = rtype(3, 6, 7); step();
    check("fp_fwd_a", 32'(bus.fwd_a), 32'd2);
    cur = rtype(1, 2, 0); step();
    cur = rtype(4, 5, 0); step();
    cur = rtype(0, 6, 7); step();
    check("fp_zero_fwd_a", 32'(bus.fwd_a), 32'd0);

    // Taken branch coinciding with a load-use condition
    cur = lw(9, 8);
    cur.Branch = 1'b1;
    step();
    cur = rtype(8, 10, 11);
    cur.zero = 1'b1;
    probe();
    check("sim_pc_write",   32'(bus.pc_write),   32'd1);
    check("sim_ifid_flush", 32'(bus.ifid_flush), 32'd1);
    step();
    check("sim_stall_cnt", 32'(bus.stall_cnt), 32'd1);
    check("sim_flush_cnt", 32'(bus.flush_cnt), 32'd2);

    // Drive the narrow counter into saturation
    for (int i = 0; i < 4; i++) begin
      cur = lw(0, 8);       step();
      cur = rtype(8, 0, 1); step();
    end
    check("sat_stall_hold", 32'(sbus.stall_cnt), 32'd3);
    check("wide_stall_cnt", 32'(bus.stall_cnt),  32'd5);

    // Random traffic on a small register set, with occasional mid-stream reset
    for (int i = 0; i < 600; i++) begin
      cur    = IN_W'($urandom());
      cur.rs = 5'($urandom_range(0, 3));
      cur.rt = 5'($urandom_range(0, 3));
      cur.rd = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) mid_reset();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
